// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-tick divider, x/y counters, registered sync/video/frame strobes.
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int PIX_DIV = 2,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_r, div_nxt_s;
  logic [9:0]       x_r, y_r, x_nxt_s, y_nxt_s;
  logic             hsync_n_r, vsync_n_r, video_on_r, frame_start_r;
  logic             p_tick_s, wrap_s, hs_nxt_s, vs_nxt_s, vo_nxt_s;

  assign p_tick_s = enable && (div_r == DIV_LAST);

  // Next-state divider/counters plus sync decode of the next position (zero skew to x/y).
  always_comb begin
    div_nxt_s = div_r;
    x_nxt_s   = x_r;
    y_nxt_s   = y_r;
    wrap_s    = 1'b0;
    if (enable) begin
      if (div_r == DIV_LAST) begin
        div_nxt_s = '0;
      end else begin
        div_nxt_s = div_r + DIV_ONE;
      end
    end else begin
      div_nxt_s = div_r;
    end
    if (p_tick_s) begin
      if (x_r == H_LAST) begin
        x_nxt_s = 10'd0;
        if (y_r == V_LAST) begin
          y_nxt_s = 10'd0;
          wrap_s  = 1'b1;
        end else begin
          y_nxt_s = y_r + 10'd1;
        end
      end else begin
        x_nxt_s = x_r + 10'd1;
      end
    end else begin
      x_nxt_s = x_r;
    end
    hs_nxt_s = !((x_nxt_s >= HS_START) && (x_nxt_s <= HS_END));
    vs_nxt_s = !((y_nxt_s >= VS_START) && (y_nxt_s <= VS_END));
    vo_nxt_s = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
  end

  // Raster state and decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r         <= '0;
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      hsync_n_r     <= 1'b1;
      vsync_n_r     <= 1'b1;
      video_on_r    <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      div_r         <= div_nxt_s;
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      hsync_n_r     <= hs_nxt_s;
      vsync_n_r     <= vs_nxt_s;
      video_on_r    <= vo_nxt_s;
      frame_start_r <= wrap_s;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Free-running frame count for blink timing; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 8'd0;
    end else if (wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign p_tick      = p_tick_s;
  assign x           = x_r;
  assign y           = y_r;
  assign hsync_n     = hsync_n_r;
  assign vsync_n     = vsync_n_r;
  assign video_on    = video_on_r;
  assign frame_start = frame_start_r;

endmodule
